// File: rtl/imm_instr_packer_pkg.sv
// Shared definitions for the RV32I instruction packer: format codes (same encoding
// as the extender's ImmSrc), opcode constants and the request payload.
package imm_instr_packer_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100,
    FMT_R = 3'b101
  } immFmt_e;

  localparam int unsigned INSTR_W = 32;

  // addi x0,x0,0 substituted for any word that cannot be encoded
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [2:0]         fmt;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [INSTR_W-1:0] imm;
  } packReq_t;

endpackage

// File: rtl/imm_pack_field.sv
// Combinational field packer: places the immediate and register fields for one
// format and flags immediates the format cannot represent.
module imm_pack_field
  import imm_instr_packer_pkg::*;
(
  input  packReq_t            req,
  output logic [INSTR_W-1:0]  instr,
  output logic                err
);

  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b0;
    case (req.fmt)
      FMT_I: begin
        err   = !((&req.imm[31:11]) || !(|req.imm[31:11]));
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      FMT_S: begin
        err   = !((&req.imm[31:11]) || !(|req.imm[31:11]));
        instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      end
      FMT_B: begin
        err   = req.imm[0] || !((&req.imm[31:12]) || !(|req.imm[31:12]));
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
      end
      FMT_J: begin
        err   = req.imm[0] || !((&req.imm[31:20]) || !(|req.imm[31:20]));
        instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
      end
      FMT_U: begin
        err   = |req.imm[11:0];
        instr = {req.imm[31:12], req.rd, req.opcode};
      end
      FMT_R: begin
        instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      end
      default: err = 1'b1;
    endcase
    if (err) instr = NOP_INSTR;
  end

endmodule

// File: rtl/imm_instr_packer.sv
// Two-stage valid/ready packer feeding the instruction-memory load path; tags each
// word with a running byte address and counts unencodable words.
module imm_instr_packer
  import imm_instr_packer_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
  parameter int unsigned          ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [INSTR_W-1:0]    imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_err,
  input  logic                  addr_load,
  input  logic [ADDR_W-1:0]     addr_value,
  output logic [ERR_CNT_W-1:0]  err_count
);

  logic               s1Valid;
  packReq_t           s1Req;
  packReq_t           inReq;
  logic               s2Advance;
  logic               s1Advance;
  logic               outHandshake;
  logic [INSTR_W-1:0] packInstr;
  logic               packErr;

  assign inReq        = {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm};
  assign s2Advance    = !out_valid || out_ready;
  assign s1Advance    = s1Valid && s2Advance;
  assign in_ready     = !s1Valid || s1Advance;
  assign outHandshake = out_valid && out_ready;

  // Stage 1: request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Req   <= '0;
    end else if (in_ready) begin
      s1Valid <= in_valid;
      if (in_valid) s1Req <= inReq;
    end
  end

  imm_pack_field uPack (
    .req   (s1Req),
    .instr (packInstr),
    .err   (packErr)
  );

  // Stage 2: packed word held stable until downstream accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_instr <= packInstr;
        out_err   <= packErr;
      end
    end
  end

  // Address of the word currently on the output; a load takes priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= RESET_ADDR;
    end else if (addr_load) begin
      out_addr <= addr_value;
    end else if (outHandshake) begin
      out_addr <= out_addr + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (outHandshake && out_err && !(&err_count)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_instr_packer.sv
// Directed bench for imm_instr_packer: hand-computed encodings, streaming,
// backpressure, address load/wrap, mid-flight reset and an extender round trip.
module tb_imm_instr_packer;
  import imm_instr_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        addr_load;
  logic [31:0] addr_value;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] expAddr;
  int          expErrCnt;

  logic [31:0] qInstr[$];
  logic [31:0] qAddr[$];
  logic        qErr[$];
  int          qCyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  imm_instr_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .err_count  (err_count)
  );

  // Output handshakes, sampled half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      qInstr.push_back(out_instr);
      qAddr.push_back(out_addr);
      qErr.push_back(out_err);
      qCyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic qClear();
    qInstr.delete(); qAddr.delete(); qErr.delete(); qCyc.delete();
  endtask

  function automatic logic [31:0] iWord(input int v);
    return (32'(v) << 20) | (32'(v) << 7) | 32'h13;
  endfunction

  // Reference immediate extender (decode direction)
  function automatic logic [31:0] ext(input logic [31:0] i, input logic [2:0] f);
    case (f)
      FMT_I:   ext = {{20{i[31]}}, i[31:20]};
      FMT_S:   ext = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   ext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_J:   ext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      FMT_U:   ext = {i[31:12], 12'b0};
      default: ext = i;
    endcase
  endfunction

  task automatic setReq(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic issue(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    int n = 0;
    setReq(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitOut(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic runVec(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] expI, input logic expE);
    issue(f, op, d, s1, s2, f3, f7, im);
    waitOut(tag);
    chk({tag, "_instr"}, out_instr, expI);
    chk({tag, "_err"}, 32'(out_err), 32'(expE));
    chk({tag, "_addr"}, out_addr, expAddr);
    expAddr = expAddr + 32'd4;
    if (expE) expErrCnt++;
    tick();
    chk({tag, "_errcnt"}, 32'(err_count), 32'(expErrCnt));
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] raw;
    logic [31:0] rImm;
    logic [2:0]  rFmt;
    logic [6:0]  rOp;
    int k;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
    setReq(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    expAddr = 32'h0; expErrCnt = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_out_addr", out_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // I type with 2-cycle latency; rs2 must not leak into the word
    setReq(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd7, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    chk("i_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("i_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("i_lat2_valid", 32'(out_valid), 32'd1);
    chk("i_instr", out_instr, 32'hFFF1_0093);
    chk("i_err", 32'(out_err), 32'd0);
    chk("i_addr", out_addr, 32'h0);
    tick();
    expAddr = 32'h4;
    chk("i_addr_inc", out_addr, expAddr);

    runVec("b_neg4",   FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    runVec("b_odd",    FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, NOP_INSTR, 1'b1);
    runVec("u_lui",    FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    runVec("j_max",    FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574,   32'h7FFF_F0EF, 1'b0);
    runVec("j_over",   FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,   NOP_INSTR, 1'b1);
    runVec("s_sw",     FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE20_AC23, 1'b0);
    runVec("i_over",   FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, NOP_INSTR, 1'b1);
    runVec("r_sub",    FMT_R, OP_REG,    5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    runVec("reserved", 3'b110, OP_IMM,   5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,         NOP_INSTR, 1'b1);

    // Address load, then 8 back-to-back words
    addr_load = 1'b1; addr_value = 32'h100;
    tick();
    addr_load = 1'b0;
    chk("load_addr", out_addr, 32'h100);
    qClear();
    for (int i = 0; i < 8; i++) begin
      setReq(FMT_I, OP_IMM, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      in_valid = 1'b1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_count", 32'(qInstr.size()), 32'd8);
    for (int i = 0; i < 8 && i < qInstr.size(); i++) begin
      chk("stream_instr", qInstr[i], iWord(i));
      chk("stream_addr", qAddr[i], 32'h100 + 32'(4 * i));
      chk("stream_err", 32'(qErr[i]), 32'd0);
      chk("stream_rate", 32'(qCyc[i] - qCyc[0]), 32'(i));
    end

    // Backpressure: out_ready low for 3 cycles while both stages are full
    qClear();
    k = 0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 4 && c < 7);
      #1;
      if (c >= 4 && c < 7) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        if (c == 4) begin
          held = out_instr;
          chk("bp_held_word", out_instr, iWord(10));
        end else begin
          chk("bp_stable", out_instr, held);
        end
      end
      if (k < 6 && in_ready) begin
        setReq(FMT_I, OP_IMM, 5'(k + 8), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 8));
        in_valid = 1'b1;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(qInstr.size()), 32'd6);
    for (int i = 0; i < 6 && i < qInstr.size(); i++) begin
      chk("bp_instr", qInstr[i], iWord(i + 8));
      chk("bp_addr", qAddr[i], 32'h120 + 32'(4 * i));
    end

    // Load coincident with a handshake: departing word keeps old address
    expAddr = 32'h138;
    issue(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    waitOut("coinc");
    chk("coinc_old_addr", out_addr, expAddr);
    addr_load = 1'b1; addr_value = 32'h2000;
    tick();
    addr_load = 1'b0;
    chk("coinc_new_addr", out_addr, 32'h2000);
    chk("coinc_departed", qAddr[qAddr.size() - 1], 32'h138);
    expAddr = 32'h2000;
    runVec("after_load", FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, iWord(2), 1'b0);

    // Address wrap at the top of the space
    addr_load = 1'b1; addr_value = 32'hFFFF_FFFC;
    tick();
    addr_load = 1'b0;
    expAddr = 32'hFFFF_FFFC;
    runVec("wrap", FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, iWord(3), 1'b0);
    chk("wrap_addr", out_addr, 32'h0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    issue(FMT_I, OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    issue(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    addr_load = 1'b1; addr_value = 32'h40;
    tick();
    addr_load = 1'b0;
    qClear();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_errcnt", 32'(err_count), 32'd0);
    chk("mid_rst_addr", out_addr, 32'h0);
    chk("mid_rst_instr", out_instr, 32'd0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_stale", 32'(qInstr.size()), 32'd0);
    expAddr = 32'h0; expErrCnt = 0;

    // Round trip through the reference extender
    for (int it = 0; it < 24; it++) begin
      rFmt = 3'($urandom_range(0, 5));
      raw  = $urandom;
      rOp  = 7'($urandom);
      case (rFmt)
        FMT_I, FMT_S: rImm = {{20{raw[11]}}, raw[11:0]};
        FMT_B:        rImm = {{19{raw[12]}}, raw[12:1], 1'b0};
        FMT_J:        rImm = {{11{raw[20]}}, raw[20:1], 1'b0};
        FMT_U:        rImm = {raw[31:12], 12'b0};
        default:      rImm = raw;
      endcase
      issue(rFmt, rOp, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rImm);
      waitOut("rt");
      chk("rt_err", 32'(out_err), 32'd0);
      chk("rt_opcode", 32'(out_instr[6:0]), 32'(rOp));
      chk("rt_addr", out_addr, expAddr);
      if (rFmt != FMT_R) chk("rt_imm", ext(out_instr, rFmt), rImm);
      expAddr = expAddr + 32'd4;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_instr_packer.md
Name: imm_instr_packer

Overview:
- Inverse of the immediate extender: packs opcode, register and function fields and a 32-bit immediate into a RV32I instruction word.
- Uses the same 3-bit format code as ImmSrc.
- Feeds the instruction-memory load path (boot loader, self-test programs) through a 2-stage valid/ready pipeline.
- Tags each word with an auto-incrementing byte address and flags immediates that are not representable.

Parameters:
- ADDR_W, 32, width of the output byte address.
- RESET_ADDR, 32'h0, value of the address counter after reset.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  packer can accept a request.
- fmt  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110/111 reserved.
- opcode  in  7  instruction bits [6:0].
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  bits [14:12].
- funct7  in  7  bits [31:25]; R format only.
- imm  in  32  immediate value as the extender would produce it.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_err  out  1  immediate unrepresentable or fmt reserved.
- addr_load  in  1  load the address counter.
- addr_value  in  ADDR_W  new base address.
- err_count  out  ERR_CNT_W  saturating count of erroneous words.

Behaviour:
- Reset (asynchronous, rst_n low) forces:
  - out_valid=0, out_instr=0, out_err=0, err_count=0, out_addr=RESET_ADDR.
  - Both pipeline valid bits cleared; any in-flight request is dropped.
  - in_ready=1 from the first cycle after release.
- Stage 1 (check), captured on in_valid&&in_ready. Error rules:
  - I, S: error unless imm[31:11] are all equal.
  - B: error unless imm[0]==0 and imm[31:12] are all equal.
  - J: error unless imm[0]==0 and imm[31:20] are all equal.
  - U: error unless imm[11:0]==0.
  - R: imm ignored, never an error.
  - 110/111: always an error.
- Stage 2 (pack), common fields: [6:0]=opcode, [11:7]=rd, [14:12]=funct3, [19:15]=rs1, [24:20]=rs2.
  - I: [31:20]=imm[11:0]; rs2 field ignored.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
  - R: [31:25]=funct7.
  - Fields not listed for a format come from the common fields.
- Error output: out_instr=32'h0000_0013 (addi x0,x0,0) and out_err=1.
  - The erroneous word still consumes an address, so the address stream has no holes.
- Round-trip invariant: for every non-error word, extending out_instr[31:7] with the same fmt returns imm exactly.
- Latency and flow control:
  - Latency is 2 cycles from input handshake to out_valid with out_ready held high.
  - Throughput is 1 word per cycle.
  - Stall: stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or draining.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready; no skid buffer).
  - Outputs are stable while out_valid && !out_ready.
- Address counter: out_addr advances by 4 on each output handshake and wraps modulo 2^ADDR_W.
  - addr_load alone: out_addr=addr_value next cycle.
  - addr_load together with an output handshake: the departing word keeps the old address; the next word uses addr_value (load wins over increment).
- err_count: +1 on each handshake of a word with out_err=1; saturates at all-ones.

Decomposition:
- Shared package holds:
  - the fmt codes (FMT_I..FMT_R), common with the extender's ImmSrc;
  - the NOP constant 32'h0000_0013;
  - the opcode constants.
- One combinational sub-module, imm_pack_field (fmt, imm, fields -> instr, err), instantiated in stage 2 and reusable by the bench as a reference model.

Test Plan:
- I type: fmt=000, opcode=0010011, rd=1, rs1=2, funct3=0, imm=-1 -> out_instr=32'hFFF10093, out_err=0, 2-cycle latency.
- B type: fmt=010, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> out_instr=32'hFE208EE3. Same request with imm=3 -> out_instr=32'h00000013, out_err=1, err_count=1.
- Streaming: 8 back-to-back valid words with out_ready=1 after addr_load of 32'h100 -> one word per cycle, addresses 0x100..0x11C.
- Backpressure: out_ready low for 3 cycles mid-stream -> outputs held stable, in_ready low once both stages are full, no word lost or duplicated.
- Boundaries:
  - U type imm=32'h12345000 -> out_instr[31:12]=0x12345.
  - J type imm=1048574 -> accepted.
  - J type imm=1048576 -> error.
  - addr_load coincident with a handshake -> load wins over increment.
- Reset: assert rst_n low while both stages are valid -> out_valid=0 and err_count=0 immediately, out_addr=RESET_ADDR, no stale word after release.
- Random round-trip: every non-error word fed through the extender returns imm.
